// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared state encoding, width helpers and constants for the Sudoku board datapath
package sudoku_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int EMPTY = 0;

    function automatic int f_cells(input int n);
        return n * n;
    endfunction

    function automatic int f_vw(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int f_iw(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int f_cw(input int n);
        return $clog2(n * n + 1);
    endfunction

endpackage

// File: rtl/sudoku_cell_array.sv
// rtl/sudoku_cell_array.sv - solution/clue/user register file with one write port and combinational reads
module sudoku_cell_array
    import sudoku_pkg::*;
#(
    parameter  int N     = 4,
    localparam int CELLS = f_cells(N),
    localparam int VW    = f_vw(N),
    localparam int IW    = f_iw(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_en,
    input  logic [IW-1:0] i_load_idx,
    input  logic [VW-1:0] i_load_value,
    input  logic          i_load_given,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [VW-1:0] i_wr_value,
    input  logic          i_clear,
    input  logic [IW-1:0] i_rd_idx,
    output logic [VW-1:0] o_rd_value,
    output logic          o_rd_given,
    input  logic [IW-1:0] i_scan_idx,
    output logic [VW-1:0] o_scan_user,
    output logic [VW-1:0] o_scan_sol,
    output logic [VW-1:0] o_wr_user,
    output logic          o_wr_given
);

    logic [VW-1:0]    r_sol  [CELLS];
    logic [VW-1:0]    r_user [CELLS];
    logic [CELLS-1:0] r_given;

    logic w_rd_ok;
    logic w_wr_idx_ok;

    // Clear outranks everything; the controller never asserts load and write together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_given <= '0;
            for (int i = 0; i < CELLS; i++) begin
                r_sol[i]  <= VW'(EMPTY);
                r_user[i] <= VW'(EMPTY);
            end
        end else if (i_clear) begin
            for (int i = 0; i < CELLS; i++) begin
                if (!r_given[i]) begin
                    r_user[i] <= VW'(EMPTY);
                end
            end
        end else if (i_load_en) begin
            r_sol[i_load_idx]   <= i_load_value;
            r_given[i_load_idx] <= i_load_given;
            r_user[i_load_idx]  <= i_load_given ? i_load_value : VW'(EMPTY);
        end else if (i_wr_en) begin
            r_user[i_wr_idx] <= i_wr_value;
        end
    end

    assign w_rd_ok     = (int'(i_rd_idx) < CELLS);
    assign w_wr_idx_ok = (int'(i_wr_idx) < CELLS);

    assign o_rd_value  = w_rd_ok ? r_user[i_rd_idx] : VW'(EMPTY);
    assign o_rd_given  = w_rd_ok ? r_given[i_rd_idx] : 1'b0;
    assign o_scan_user = r_user[i_scan_idx];
    assign o_scan_sol  = r_sol[i_scan_idx];
    assign o_wr_user   = w_wr_idx_ok ? r_user[i_wr_idx] : VW'(EMPTY);
    assign o_wr_given  = w_wr_idx_ok ? r_given[i_wr_idx] : 1'b0;

endmodule

// File: rtl/sudoku_board_dp.sv
// rtl/sudoku_board_dp.sv - Sudoku board datapath: puzzle load, guarded player writes, sequential solution scan
module sudoku_board_dp
    import sudoku_pkg::*;
#(
    parameter  int N     = 4,
    localparam int CELLS = f_cells(N),
    localparam int VW    = f_vw(N),
    localparam int IW    = f_iw(N),
    localparam int CW    = f_cw(N)
) (
    input  logic          clka,
    input  logic          restart_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [VW-1:0] load_value,
    input  logic          load_given,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [VW-1:0] wr_value,
    output logic          wr_ack,
    output logic          wr_rejected,
    input  logic          clear_user,
    input  logic          check_start,
    output logic          check_busy,
    output logic          check_done,
    output logic          solved,
    output logic [CW-1:0] mismatch_count,
    output logic [IW-1:0] first_mismatch_idx,
    output logic [CW-1:0] filled_count,
    input  logic [IW-1:0] rd_idx,
    output logic [VW-1:0] rd_value,
    output logic          rd_given
);

    state_t        r_state;
    logic [IW-1:0] r_cursor, r_scan_idx, r_scan_first, r_first;
    logic [CW-1:0] r_scan_cnt, r_clue_cnt, r_filled, r_mis_cnt;
    logic          r_load_ready, r_wr_ack, r_wr_rej, r_busy, r_done, r_solved;

    logic [VW-1:0] w_wr_old, w_scan_user, w_scan_sol;
    logic          w_wr_given, w_ready, w_load_fire, w_load_nz, w_load_last;
    logic          w_clear, w_wr_ok, w_scan_mis, w_scan_last;
    logic [CW-1:0] w_cnt_next;
    logic [IW-1:0] w_first_next;

    assign w_ready      = (r_state == S_READY);
    assign w_load_fire  = (r_state == S_LOAD) && load_valid && r_load_ready;
    assign w_load_nz    = load_given && (load_value != '0);
    assign w_load_last  = (r_cursor == IW'(CELLS - 1));
    assign w_clear      = w_ready && clear_user;
    assign w_wr_ok      = w_ready && wr_en && !clear_user && !w_wr_given
                          && (int'(wr_value) <= N) && (int'(wr_idx) < CELLS);
    assign w_scan_mis   = (w_scan_user != w_scan_sol);
    assign w_scan_last  = (r_scan_idx == IW'(CELLS - 1));
    assign w_cnt_next   = r_scan_cnt + CW'(w_scan_mis);
    assign w_first_next = (w_scan_mis && r_scan_cnt == '0) ? r_scan_idx : r_scan_first;

    sudoku_cell_array #(.N(N)) u_cells (
        .i_clk        (clka),
        .i_rst_n      (restart_n),
        .i_load_en    (w_load_fire),
        .i_load_idx   (r_cursor),
        .i_load_value (load_value),
        .i_load_given (load_given),
        .i_wr_en      (w_wr_ok),
        .i_wr_idx     (wr_idx),
        .i_wr_value   (wr_value),
        .i_clear      (w_clear),
        .i_rd_idx     (rd_idx),
        .o_rd_value   (rd_value),
        .o_rd_given   (rd_given),
        .i_scan_idx   (r_scan_idx),
        .o_scan_user  (w_scan_user),
        .o_scan_sol   (w_scan_sol),
        .o_wr_user    (w_wr_old),
        .o_wr_given   (w_wr_given)
    );

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            r_state      <= S_LOAD;
            r_cursor     <= '0;
            r_scan_idx   <= '0;
            r_scan_first <= '0;
            r_scan_cnt   <= '0;
            r_clue_cnt   <= '0;
            r_filled     <= '0;
            r_load_ready <= 1'b1;
            r_wr_ack     <= 1'b0;
            r_wr_rej     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_solved     <= 1'b0;
            r_mis_cnt    <= '0;
            r_first      <= '0;
        end else begin
            r_wr_ack <= 1'b0;
            r_wr_rej <= 1'b0;
            r_done   <= 1'b0;

            // Tracks nonzero user cells on the same edge the board changes.
            if (w_clear) begin
                r_filled <= r_clue_cnt;
            end else if (w_wr_ok) begin
                if (w_wr_old == '0 && wr_value != '0) begin
                    r_filled <= r_filled + CW'(1);
                end else if (w_wr_old != '0 && wr_value == '0) begin
                    r_filled <= r_filled - CW'(1);
                end
            end else if (w_load_fire && w_load_nz) begin
                r_filled <= r_filled + CW'(1);
            end

            case (r_state)
                S_LOAD: begin
                    if (w_load_fire) begin
                        r_cursor <= r_cursor + IW'(1);
                        if (w_load_nz) begin
                            r_clue_cnt <= r_clue_cnt + CW'(1);
                        end
                        if (w_load_last) begin
                            r_state      <= S_READY;
                            r_load_ready <= 1'b0;
                        end
                    end
                end
                S_READY: begin
                    if (wr_en) begin
                        r_wr_ack <= w_wr_ok;
                        r_wr_rej <= !w_wr_ok;
                    end
                    if (check_start) begin
                        r_state      <= S_CHECK;
                        r_busy       <= 1'b1;
                        r_scan_idx   <= '0;
                        r_scan_cnt   <= '0;
                        r_scan_first <= '0;
                    end
                end
                S_CHECK: begin
                    if (wr_en) begin
                        r_wr_rej <= 1'b1;
                    end
                    r_scan_cnt   <= w_cnt_next;
                    r_scan_first <= w_first_next;
                    r_scan_idx   <= r_scan_idx + IW'(1);
                    if (w_scan_last) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_mis_cnt <= w_cnt_next;
                        r_solved  <= (w_cnt_next == '0);
                        r_first   <= w_first_next;
                    end
                end
                S_DONE: begin
                    if (wr_en) begin
                        r_wr_rej <= 1'b1;
                    end
                    r_state <= S_READY;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign load_ready         = r_load_ready;
    assign wr_ack             = r_wr_ack;
    assign wr_rejected        = r_wr_rej;
    assign check_busy         = r_busy;
    assign check_done         = r_done;
    assign solved             = r_solved;
    assign mismatch_count     = r_mis_cnt;
    assign first_mismatch_idx = r_first;
    assign filled_count       = r_filled;

endmodule

// File: doc/sudoku_board_dp.md
Name: sudoku_board_dp

Overview:
- Parametrised board datapath for an N×N Sudoku puzzle. It holds the solution board, the given-cell (clue) mask and the user board.
- A puzzle is streamed in through a valid/ready handshake. The game FSM then issues player writes and clears.
- Solution checking is a sequential one-cell-per-cycle scan that reports solved, mismatch count and first wrong cell.
- It replaces the fixed 4×4 two-phase datapath: one clock, with clue protection and error reporting.

Parameters:
- N, 4, board side; legal cell values 1..N, 0 = empty.
- CELLS, N*N, derived; number of cells, row-major index.
- VW, $clog2(N+1), derived; value width.
- IW, $clog2(CELLS), derived; cell index width.
- CW, $clog2(CELLS+1), derived; count width.

Ports:
- clka  in  1  sole clock; all logic on rising edge.
- restart_n  in  1  synchronous active-low reset.
- load_valid  in  1  puzzle beat valid.
- load_ready  out  1  block accepts puzzle beat.
- load_value  in  VW  solution value for current cell.
- load_given  in  1  cell is a clue (shown to player).
- wr_en  in  1  player write request.
- wr_idx  in  IW  target cell.
- wr_value  in  VW  value to write (0 = erase).
- wr_ack  out  1  one-cycle pulse, write applied.
- wr_rejected  out  1  one-cycle pulse, write refused.
- clear_user  in  1  try-again: erase all non-given cells.
- check_start  in  1  start solution scan.
- check_busy  out  1  scan in progress.
- check_done  out  1  one-cycle pulse, results valid.
- solved  out  1  last scan found zero mismatches.
- mismatch_count  out  CW  wrong or empty cells in last scan.
- first_mismatch_idx  out  IW  lowest wrong index (0 if solved).
- filled_count  out  CW  nonzero user cells, live.
- rd_idx  in  IW  display read index.
- rd_value / rd_given  out  VW / 1  user value and clue flag at rd_idx; combinational read.

Behaviour:
- Reset (restart_n=0 at edge):
  - All boards and the mask cleared.
  - FSM goes to LOAD with load cursor 0.
  - All outputs 0 except load_ready=1 from the first post-reset cycle.
  - Reset mid-load or mid-scan aborts immediately.
- FSM states: LOAD → READY → CHECK → DONE → READY.
- LOAD:
  - load_ready=1; a beat is accepted when load_valid&load_ready.
  - Each beat writes solution[cursor]=load_value and given[cursor]=load_given.
  - It also writes user[cursor]=load_given ? load_value : 0, then increments cursor.
  - After beat CELLS-1: next cycle READY, load_ready=0.
  - wr_en, clear_user and check_start are ignored in LOAD; no ack or reject.
  - load_value 0 or >N is stored as given (bench responsibility); no error.
- READY, wr_en:
  - Reject if given[wr_idx], wr_value>N, or wr_idx≥CELLS. Otherwise user[wr_idx]=wr_value.
  - wr_ack or wr_rejected pulses in the cycle after the request; exactly one of them per request.
  - filled_count is updated in the same edge as the write: +1 for 0→nonzero, −1 for nonzero→0, unchanged otherwise.
- READY, clear_user:
  - Every non-given cell is set to 0 in one cycle; filled_count becomes the number of clues.
  - If wr_en and clear_user occur in the same cycle, clear wins and the write is rejected.
- READY, check_start:
  - Next cycle enters CHECK, check_busy=1, scan index 0, counters cleared.
  - If wr_en occurs in the same cycle, the write is applied first and the scan sees it.
  - If clear_user occurs in the same cycle, the clear is applied, then the scan runs.
- CHECK:
  - One cell per cycle, index 0..CELLS-1, takes CELLS cycles.
  - A cell mismatches if user≠solution; empty counts as mismatch.
  - first_mismatch_idx latches on the first mismatch only.
  - wr_en gives wr_rejected; clear_user and check_start are ignored.
- DONE:
  - Lasts one cycle: check_done=1, check_busy=0.
  - solved = (mismatch_count==0).
  - solved, mismatch_count and first_mismatch_idx hold until the next scan's DONE or reset.
  - Then returns to READY.
- Latency:
  - check_start to check_done = CELLS+2 cycles, i.e. 18 for N=4.
  - filled_count saturates at CELLS by construction.
- rd_value/rd_given are valid in every state and reflect registered contents.

Decomposition:
- Package sudoku_pkg holds:
  - state enum (LOAD, READY, CHECK, DONE);
  - the N-derived width functions;
  - the EMPTY constant (0).
- One sub-module, sudoku_cell_array: CELLS×(VW+VW+1) register file. It has one write port (load, or user write, or clear) and two combinational read ports (rd_idx, scan index).
- The FSM, counters and handshake logic stay in sudoku_board_dp.

Test Plan:
- Reset, then load 16 beats of a valid 4×4 solution with given=1 on cells 0,5,10,15 → READY after beat 15; filled_count=4; rd_value(5) = solution[5]; load_ready=0.
- Write value 3 to given cell 5 → wr_rejected one cycle later, cell unchanged. Write value 5 to cell 1 → rejected. Write value 2 to cell 1 → wr_ack, filled_count=5.
- Fill all 12 free cells correctly, then check_start → check_busy for 16 cycles; check_done at cycle 18; solved=1, mismatch_count=0.
- Set cell 7 wrong and leave cell 12 empty, then check → solved=0, mismatch_count=2, first_mismatch_idx=7. wr_en during CHECK → wr_rejected.
- clear_user and wr_en in the same cycle → wr_rejected; all non-clue cells 0; filled_count=4. Then check → mismatch_count=12.
- Assert restart_n=0 at load beat 9 and at scan cycle 6 → FSM in LOAD, cursor 0, all outputs cleared, load_ready=1.
